// File: rtl/mac_rx_frame_reader.sv
// Read-side consumer of one MAC port's RX queues: pops a frame descriptor, then
// forwards or drains exactly that many bytes from the RX data FIFO.
module mac_rx_frame_reader #(
  parameter int unsigned MAX_LEN = 1536,
  parameter int unsigned MIN_LEN = 60
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rx_ptr_fifo_rd,
  input  logic [19:0] rx_ptr_fifo_dout,
  input  logic        rx_ptr_fifo_empty,
  output logic        rx_data_fifo_rd,
  input  logic [8:0]  rx_data_fifo_dout,
  output logic        o_valid,
  output logic [7:0]  o_data,
  output logic        o_sof,
  output logic        o_eof,
  output logic [6:0]  o_tag,
  input  logic        i_ready,
  output logic [15:0] frm_fwd_cnt,
  output logic [15:0] frm_drop_cnt,
  output logic        sync_err
);

  localparam logic [11:0] MAX_L = 12'(MAX_LEN);
  localparam logic [11:0] MIN_L = 12'(MIN_LEN);

  typedef enum logic [1:0] {IDLE, PTR, FWD, DRAIN} state_t;
  state_t state, state_nxt;

  logic [11:0] len, rem, ret_cnt;
  logic        rd_q;
  logic [1:0]  occ;
  logic [9:0]  skid0, skid1;  // {eof, sof, data}; skid0 is the head

  logic [11:0] d_len;
  logic        d_err;
  logic [6:0]  d_tag;
  logic        ptr_zero, ptr_bad;
  logic        accept, push, credit_ok;
  logic        ret_first, ret_last;
  logic        fwd_done, drain_done, drop_evt;
  logic [9:0]  ret_entry;

  assign d_len = rx_ptr_fifo_dout[11:0];
  assign d_err = rx_ptr_fifo_dout[12];
  assign d_tag = rx_ptr_fifo_dout[19:13];

  assign ptr_zero = (d_len == '0);
  assign ptr_bad  = d_err || (d_len < MIN_L) || (d_len > MAX_L);

  assign o_valid = (occ != 2'd0);
  assign o_data  = skid0[7:0];
  assign o_sof   = o_valid & skid0[8];
  assign o_eof   = o_valid & skid0[9];

  assign accept    = o_valid & i_ready;
  assign ret_first = (ret_cnt == '0);
  assign ret_last  = (ret_cnt == len - 12'd1);
  assign ret_entry = {ret_last, ret_first, rx_data_fifo_dout[7:0]};
  assign push      = rd_q && (state == FWD);

  // Credit counts the slot freed by this cycle's accept, so a full-rate
  // stream keeps one byte buffered and one in flight.
  assign credit_ok = ({1'b0, occ} + {2'b00, rd_q}) < (3'd2 + {2'b00, accept});

  assign fwd_done   = (state == FWD) && accept && o_eof;
  assign drain_done = (state == DRAIN) && (rem == '0) && rd_q;
  assign drop_evt   = drain_done || ((state == PTR) && ptr_zero);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (!rx_ptr_fifo_empty) state_nxt = PTR;
      PTR: begin
        if (ptr_zero)     state_nxt = IDLE;
        else if (ptr_bad) state_nxt = DRAIN;
        else              state_nxt = FWD;
      end
      FWD:   if (fwd_done)   state_nxt = IDLE;
      DRAIN: if (drain_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rx_ptr_fifo_rd  = 1'b0;
    rx_data_fifo_rd = 1'b0;
    if (!rst) begin
      rx_ptr_fifo_rd  = (state == IDLE) && !rx_ptr_fifo_empty;
      rx_data_fifo_rd = (rem != '0) &&
                        ((state == DRAIN) || ((state == FWD) && credit_ok));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len          <= '0;
      rem          <= '0;
      ret_cnt      <= '0;
      rd_q         <= 1'b0;
      occ          <= 2'd0;
      skid0        <= '0;
      skid1        <= '0;
      o_tag        <= '0;
      frm_fwd_cnt  <= '0;
      frm_drop_cnt <= '0;
      sync_err     <= 1'b0;
    end else begin
      rd_q <= rx_data_fifo_rd;

      if (state == PTR) begin
        len     <= d_len;
        rem     <= d_len;
        ret_cnt <= '0;
        o_tag   <= d_tag;
      end else begin
        if (rx_data_fifo_rd) rem     <= rem - 12'd1;
        if (rd_q)            ret_cnt <= ret_cnt + 12'd1;
      end

      // The SOF marker must be set on exactly the first byte of each frame.
      if (rd_q && (ret_first != rx_data_fifo_dout[8])) sync_err <= 1'b1;

      if (fwd_done && (frm_fwd_cnt != '1))  frm_fwd_cnt  <= frm_fwd_cnt + 16'd1;
      if (drop_evt && (frm_drop_cnt != '1)) frm_drop_cnt <= frm_drop_cnt + 16'd1;

      case ({push, accept})
        2'b10: begin
          if (occ == 2'd0) skid0 <= ret_entry;
          else             skid1 <= ret_entry;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          skid0 <= skid1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            skid0 <= ret_entry;
          end else begin
            skid0 <= skid1;
            skid1 <= ret_entry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_rx_frame_reader.sv
// Self-checking bench for mac_rx_frame_reader: FIFO models with 1-cycle read
// latency and a frame-level reference model built from queued descriptors.
module tb_mac_rx_frame_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_ptr_fifo_rd;
  logic [19:0] rx_ptr_fifo_dout;
  logic        rx_ptr_fifo_empty;
  logic        rx_data_fifo_rd;
  logic [8:0]  rx_data_fifo_dout;
  logic        o_valid;
  logic [7:0]  o_data;
  logic        o_sof;
  logic        o_eof;
  logic [6:0]  o_tag;
  logic        i_ready;
  logic [15:0] frm_fwd_cnt;
  logic [15:0] frm_drop_cnt;
  logic        sync_err;

  always #5 clk = ~clk;

  mac_rx_frame_reader #(.MAX_LEN(1536), .MIN_LEN(60)) dut (
    .clk               (clk),
    .rst               (rst),
    .rx_ptr_fifo_rd    (rx_ptr_fifo_rd),
    .rx_ptr_fifo_dout  (rx_ptr_fifo_dout),
    .rx_ptr_fifo_empty (rx_ptr_fifo_empty),
    .rx_data_fifo_rd   (rx_data_fifo_rd),
    .rx_data_fifo_dout (rx_data_fifo_dout),
    .o_valid           (o_valid),
    .o_data            (o_data),
    .o_sof             (o_sof),
    .o_eof             (o_eof),
    .o_tag             (o_tag),
    .i_ready           (i_ready),
    .frm_fwd_cnt       (frm_fwd_cnt),
    .frm_drop_cnt      (frm_drop_cnt),
    .sync_err          (sync_err)
  );

  int tests, fails;
  logic [19:0] ptr_q[$];
  logic [8:0]  data_q[$];
  logic [16:0] exp_beats[$];  // {tag, sof, eof, data}
  int          frm_len_q[$];
  bit          frm_fwd_q[$];
  int          exp_fwd, exp_drop, exp_reads, reads;
  bit          exp_sync;
  int          rdy_mode, cyc, n_acc;
  int          cur_len, cur_reads, outst;
  bit          cur_fwd, have_cur, hold_v;
  logic [16:0] hold_b;
  int          t_pop, t_rd1, t_val1, t_sof, t_eof;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_frame(input int len, input bit err, input logic [6:0] tag, input bit bad_sof);
    logic [7:0]  b;
    logic [11:0] l12;
    bit          fwd;
    l12 = 12'(len);
    fwd = (len >= 60) && (len <= 1536) && !err;
    ptr_q.push_back({tag, err, l12});
    frm_len_q.push_back(len);
    frm_fwd_q.push_back(fwd);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      data_q.push_back({((i == 0) != bad_sof), b});
      if (fwd) exp_beats.push_back({tag, (i == 0), (i == len - 1), b});
    end
    if (fwd) exp_fwd++;
    else     exp_drop++;
    exp_reads += len;
    if (len > 0 && bad_sof) exp_sync = 1'b1;
    rx_ptr_fifo_empty = 1'b0;
  endtask

  task automatic step();
    logic        prd, drd, acc;
    logic [16:0] beat, eb;
    @(negedge clk);
    case (rdy_mode)
      0:       i_ready = 1'b1;
      1:       i_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: i_ready = 1'($urandom_range(0, 1));
    endcase
    #1;
    cyc++;
    prd  = rx_ptr_fifo_rd;
    drd  = rx_data_fifo_rd;
    beat = {o_tag, o_sof, o_eof, o_data};
    acc  = o_valid && i_ready;
    if (hold_v) begin
      chk("hold_valid", o_valid, 1);
      chk("hold_stable", beat, hold_b);
    end
    if (prd) begin
      if (have_cur) chk("prev_frame_reads", cur_reads, cur_len);
      chk("pop_has_frame", frm_len_q.size() > 0, 1);
      if (frm_len_q.size() > 0) begin
        cur_len = frm_len_q.pop_front();
        cur_fwd = frm_fwd_q.pop_front();
      end
      cur_reads = 0; have_cur = 1'b1; outst = 0;
      t_pop = cyc; t_rd1 = -1; t_val1 = -1;
    end
    if (drd) begin
      cur_reads++;
      reads++;
      chk("read_within_len", cur_reads <= cur_len, 1);
      if (t_rd1 < 0) t_rd1 = cyc;
      if (cur_fwd) outst++;
    end
    if (o_valid && t_val1 < 0) t_val1 = cyc;
    if (acc) begin
      outst--;
      n_acc++;
      chk("beat_expected", exp_beats.size() != 0, 1);
      if (exp_beats.size() != 0) begin
        eb = exp_beats.pop_front();
        chk("beat", beat, eb);
      end
      if (o_sof) t_sof = cyc;
      if (o_eof) t_eof = cyc;
    end
    if (drd && cur_fwd) chk("outstanding_le_2", outst <= 2, 1);
    hold_v = o_valid && !i_ready;
    hold_b = beat;
    @(posedge clk);
    #1;
    if (prd && ptr_q.size() > 0) rx_ptr_fifo_dout = ptr_q.pop_front();
    if (drd && data_q.size() > 0) rx_data_fifo_dout = data_q.pop_front();
    rx_ptr_fifo_empty = (ptr_q.size() == 0);
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int n;
    n = 0;
    while (((frm_fwd_cnt != 16'(exp_fwd)) || (frm_drop_cnt != 16'(exp_drop)) ||
            (ptr_q.size() != 0)) && (n < budget)) begin
      step();
      n++;
    end
    chk({tag, "_in_budget"}, n < budget, 1);
    repeat (3) step();
    chk({tag, "_fwd_cnt"}, frm_fwd_cnt, exp_fwd);
    chk({tag, "_drop_cnt"}, frm_drop_cnt, exp_drop);
    chk({tag, "_reads"}, reads, exp_reads);
    chk({tag, "_beats_left"}, exp_beats.size(), 0);
    chk({tag, "_data_left"}, data_q.size(), 0);
    chk({tag, "_sync_err"}, sync_err, exp_sync);
    chk({tag, "_idle_valid"}, o_valid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ptr_rd"}, rx_ptr_fifo_rd, 0);
    chk({tag, "_data_rd"}, rx_data_fifo_rd, 0);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_sof"}, o_sof, 0);
    chk({tag, "_eof"}, o_eof, 0);
    chk({tag, "_data"}, o_data, 0);
    chk({tag, "_tag"}, o_tag, 0);
    chk({tag, "_fwd_cnt"}, frm_fwd_cnt, 0);
    chk({tag, "_drop_cnt"}, frm_drop_cnt, 0);
    chk({tag, "_sync_err"}, sync_err, 0);
  endtask

  task automatic clear_model();
    ptr_q.delete(); data_q.delete(); exp_beats.delete();
    frm_len_q.delete(); frm_fwd_q.delete();
    exp_fwd = 0; exp_drop = 0; exp_reads = 0; reads = 0; exp_sync = 1'b0;
    have_cur = 1'b0; hold_v = 1'b0; outst = 0; cur_len = 0; cur_reads = 0; cur_fwd = 1'b0;
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, pick;
    tests = 0; fails = 0; cyc = 0; n_acc = 0; rdy_mode = 0;
    t_pop = 0; t_rd1 = 0; t_val1 = 0; t_sof = 0; t_eof = 0;
    clear_model();
    rst = 1'b1; i_ready = 1'b0; rx_ptr_fifo_empty = 1'b1;
    rx_ptr_fifo_dout = '0; rx_data_fifo_dout = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // 64-byte good frame at full rate
    rdy_mode = 0;
    add_frame(64, 1'b0, 7'h15, 1'b0);
    run_until_done("t1", 400);
    chk("t1_pop_to_rd", t_rd1 - t_pop, 2);
    chk("t1_rd_to_valid", t_val1 - t_rd1, 2);
    chk("t1_sof_to_eof", t_eof - t_sof, 63);

    // same frame with ready toggling 1,0,0,1
    rdy_mode = 1;
    add_frame(64, 1'b0, 7'h15, 1'b0);
    run_until_done("t2", 800);

    // errored frame drained, then a good frame
    rdy_mode = 0;
    add_frame(100, 1'b1, 7'($urandom), 1'b0);
    add_frame(64, 1'b0, 7'($urandom), 1'b0);
    run_until_done("t3", 800);

    // zero length, oversize, minimum size
    add_frame(0, 1'b0, 7'h01, 1'b0);
    add_frame(1600, 1'b0, 7'h02, 1'b0);
    add_frame(60, 1'b0, 7'h03, 1'b0);
    run_until_done("t4", 3000);

    // SOF marker missing on byte 0, then a clean frame
    add_frame(64, 1'b0, 7'h2A, 1'b1);
    add_frame(70, 1'b0, 7'h2B, 1'b0);
    run_until_done("t5", 800);

    // randomized mix with random backpressure; sync_err must stay set
    rdy_mode = 2;
    for (int f = 0; f < 14; f++) begin
      pick = int'($urandom_range(0, 9));
      case (pick)
        0:       len = 0;
        1:       len = 59;
        2:       len = 60;
        3:       len = 1537;
        4:       len = int'($urandom_range(1, 59));
        default: len = int'($urandom_range(61, 200));
      endcase
      add_frame(len, ($urandom_range(0, 7) == 0), 7'($urandom), ($urandom_range(0, 9) == 0));
    end
    run_until_done("t6", 20000);

    // reset in the middle of a frame
    rdy_mode = 0;
    n_acc = 0;
    add_frame(64, 1'b0, 7'h33, 1'b0);
    for (int i = 0; i < 200 && n_acc < 30; i++) step();
    chk("t7_reached_byte30", n_acc, 30);
    @(negedge clk);
    rst = 1'b1;
    i_ready = 1'b0;
    clear_model();
    rx_ptr_fifo_empty = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("t7_rst");
    rst = 1'b0;
    add_frame(64, 1'b0, 7'h44, 1'b0);
    run_until_done("t7_after", 400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
